// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, operand forwarding
// from EX/MEM and MEM/WB, and a saturating load-use stall counter.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc4,
  input  logic [7:0]       ctrl,
  input  logic [31:0]      regA,
  input  logic [31:0]      regB,
  input  logic             flush,
  input  logic             mem_regWrite,
  input  logic [4:0]       mem_rd,
  input  logic [31:0]      mem_result,
  input  logic             wb_regWrite,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic             stall,
  output logic             ex_valid,
  output logic [7:0]       ex_ctrl,
  output logic [31:0]      ex_pc4,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [31:0]      ex_opA,
  output logic [31:0]      ex_opB,
  output logic [31:0]      ex_aluB,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [31:0] ex_a_r;
  logic [31:0] ex_b_r;
  logic        hazard_s;
  logic [4:0]  dest_s;
  logic [31:0] imm_s;

  // Nearest producer wins; register 0 is hard-wired and never bypassed.
  function automatic logic [31:0] fwd(
    input logic [4:0]  idx,
    input logic [31:0] latched,
    input logic        m_we,
    input logic [4:0]  m_rd,
    input logic [31:0] m_val,
    input logic        w_we,
    input logic [4:0]  w_rd,
    input logic [31:0] w_val
  );
    logic [31:0] res;
    if (m_we && (m_rd != 5'd0) && (m_rd == idx)) begin
      res = m_val;
    end else if (w_we && (w_rd != 5'd0) && (w_rd == idx)) begin
      res = w_val;
    end else begin
      res = latched;
    end
    return res;
  endfunction

  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign hazard_s = ex_valid & ex_ctrl[6] & (ex_rt != 5'd0) &
                    ((ex_rt == rs) | (ex_rt == rt));
  assign stall    = hazard_s & ~flush;
  assign dest_s   = ctrl[4] ? instr[15:11] : instr[20:16];
  assign imm_s    = {{16{instr[15]}}, instr[15:0]};

  assign ex_opA  = fwd(ex_rs, ex_a_r, mem_regWrite, mem_rd, mem_result,
                       wb_regWrite, wb_rd, wb_data);
  assign ex_opB  = fwd(ex_rt, ex_b_r, mem_regWrite, mem_rd, mem_result,
                       wb_regWrite, wb_rd, wb_data);
  assign ex_aluB = ex_ctrl[3] ? ex_imm : ex_opB;

  // ID/EX register: reset, flush and load-use all collapse to an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || flush || hazard_s) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= 8'd0;
      ex_pc4   <= 32'd0;
      ex_imm   <= 32'd0;
      ex_rs    <= 5'd0;
      ex_rt    <= 5'd0;
      ex_rd    <= 5'd0;
      ex_a_r   <= 32'd0;
      ex_b_r   <= 32'd0;
    end else begin
      ex_valid <= 1'b1;
      ex_ctrl  <= ctrl;
      ex_pc4   <= pc4;
      ex_imm   <= imm_s;
      ex_rs    <= rs;
      ex_rt    <= rt;
      ex_rd    <= dest_s;
      ex_a_r   <= regA;
      ex_b_r   <= regB;
    end
  end

  // Load-use stall counter, saturating so long runs never wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected ID/EX contents are queued when an
// instruction is driven and popped for comparison after the clock edge.
module tb_id_ex_stage;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      instr, pc4, regA, regB;
  logic [7:0]       ctrl;
  logic             flush;
  logic             mem_regWrite, wb_regWrite;
  logic [4:0]       mem_rd, wb_rd;
  logic [31:0]      mem_result, wb_data;
  logic [4:0]       rs, rt, ex_rs, ex_rt, ex_rd;
  logic             stall, ex_valid;
  logic [7:0]       ex_ctrl;
  logic [31:0]      ex_pc4, ex_imm, ex_opA, ex_opB, ex_aluB;
  logic [CNT_W-1:0] stall_cnt;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .pc4(pc4), .ctrl(ctrl),
    .regA(regA), .regB(regB), .flush(flush),
    .mem_regWrite(mem_regWrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs(rs), .rt(rt), .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_pc4(ex_pc4), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_aluB(ex_aluB),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  localparam int S_VALID = 0, S_CTRL = 1, S_PC4 = 2, S_IMM = 3, S_RS = 4,
                 S_RT = 5, S_RD = 6, S_OPA = 7, S_OPB = 8, S_ALUB = 9,
                 S_CNT = 10, S_STALL = 11;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t queue_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  localparam logic [31:0] ADD_8_9_10  = 32'h012A4020;
  localparam logic [31:0] SUB_8_10_9  = 32'h01494022;
  localparam logic [31:0] LW_9_8      = 32'h8D09FFFC;
  localparam logic [31:0] LW_0_8      = 32'h8D00FFFC;
  localparam logic [31:0] ADD_3_16_17 = 32'h02111820;
  localparam logic [31:0] ADD_4_0_5   = 32'h00052020;
  localparam logic [7:0]  C_RTYPE     = 8'h90;
  localparam logic [7:0]  C_LW        = 8'hC8;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_VALID: return {31'd0, ex_valid};
      S_CTRL:  return {24'd0, ex_ctrl};
      S_PC4:   return ex_pc4;
      S_IMM:   return ex_imm;
      S_RS:    return {27'd0, ex_rs};
      S_RT:    return {27'd0, ex_rt};
      S_RD:    return {27'd0, ex_rd};
      S_OPA:   return ex_opA;
      S_OPB:   return ex_opB;
      S_ALUB:  return ex_aluB;
      S_CNT:   return {{(32-CNT_W){1'b0}}, stall_cnt};
      S_STALL: return {31'd0, stall};
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    queue_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (queue_q.size() > 0) begin
      e = queue_q.pop_front();
      check(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [7:0] c,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    instr = i; ctrl = c; regA = a; regB = b; pc4 = p;
    #1;
  endtask

  task automatic bypass_off();
    mem_regWrite = 1'b0; mem_rd = 5'd0; mem_result = 32'd0;
    wb_regWrite  = 1'b0; wb_rd  = 5'd0; wb_data    = 32'd0;
  endtask

  task automatic expect_bubble(input string tag);
    expect_val({tag, "_valid"}, S_VALID, 32'd0);
    expect_val({tag, "_ctrl"},  S_CTRL,  32'd0);
    expect_val({tag, "_rd"},    S_RD,    32'd0);
    expect_val({tag, "_pc4"},   S_PC4,   32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    instr = 32'hFFFFFFFF; ctrl = 8'hFF; regA = 32'h1234; regB = 32'h5678; pc4 = 32'h4;
    bypass_off();
    expect_bubble("reset");
    expect_val("reset_opA", S_OPA, 32'd0);
    expect_val("reset_cnt", S_CNT, 32'd0);
    tick();
    rst = 1'b0;

    // Normal issue of add $8,$9,$10
    drive(ADD_8_9_10, C_RTYPE, 32'd5, 32'd7, 32'h104);
    check("rs_comb", {27'd0, rs}, 32'd9);
    check("rt_comb", {27'd0, rt}, 32'd10);
    check("issue_stall", {31'd0, stall}, 32'd0);
    expect_val("issue_valid", S_VALID, 32'd1);
    expect_val("issue_ctrl",  S_CTRL,  32'h90);
    expect_val("issue_rs",    S_RS,    32'd9);
    expect_val("issue_rt",    S_RT,    32'd10);
    expect_val("issue_rd",    S_RD,    32'd8);
    expect_val("issue_opA",   S_OPA,   32'd5);
    expect_val("issue_opB",   S_OPB,   32'd7);
    expect_val("issue_aluB",  S_ALUB,  32'd7);
    expect_val("issue_pc4",   S_PC4,   32'h104);
    expect_val("issue_imm",   S_IMM,   32'h00004020);
    tick();

    // lw $9,-4($8): negative immediate, aluSrc selects it, rd = rt
    drive(LW_9_8, C_LW, 32'h1000, 32'h33, 32'h108);
    check("lw_stall", {31'd0, stall}, 32'd0);
    expect_val("lw_rd",   S_RD,   32'd9);
    expect_val("lw_imm",  S_IMM,  32'hFFFFFFFC);
    expect_val("lw_aluB", S_ALUB, 32'hFFFFFFFC);
    expect_val("lw_opA",  S_OPA,  32'h1000);
    tick();

    // Dependent add: one-cycle load-use stall and bubble
    drive(ADD_8_9_10, C_RTYPE, 32'd1, 32'd2, 32'h10C);
    check("lu_stall", {31'd0, stall}, 32'd1);
    expect_bubble("lu_bubble");
    expect_val("lu_opA", S_OPA, 32'd0);
    expect_val("lu_cnt", S_CNT, 32'd1);
    expect_val("lu_stall_after", S_STALL, 32'd0);
    tick();
    exp_cnt = 1;
    expect_val("lu_reissue_valid", S_VALID, 32'd1);
    expect_val("lu_reissue_rd",    S_RD,    32'd8);
    expect_val("lu_reissue_opA",   S_OPA,   32'd1);
    expect_val("lu_reissue_opB",   S_OPB,   32'd2);
    expect_val("lu_reissue_cnt",   S_CNT,   32'd1);
    tick();

    // Forwarding priority on rs=16
    drive(ADD_3_16_17, C_RTYPE, 32'h11, 32'h22, 32'h110);
    mem_regWrite = 1'b1; mem_rd = 5'd16; mem_result = 32'hAAAA0000;
    wb_regWrite  = 1'b1; wb_rd  = 5'd16; wb_data    = 32'hBBBB0000;
    expect_val("fwd_mem_opA", S_OPA, 32'hAAAA0000);
    expect_val("fwd_none_opB", S_OPB, 32'h22);
    expect_val("fwd_rd", S_RD, 32'd3);
    tick();
    mem_regWrite = 1'b0; #1;
    check("fwd_wb_opA", ex_opA, 32'hBBBB0000);
    mem_regWrite = 1'b1; mem_rd = 5'd17; wb_rd = 5'd17; #1;
    check("fwd_mem_opB", ex_opB, 32'hAAAA0000);
    check("fwd_rt_only_opA", ex_opA, 32'h11);
    mem_regWrite = 1'b0; #1;
    check("fwd_wb_opB", ex_opB, 32'hBBBB0000);
    bypass_off();

    // Register 0 is never forwarded
    drive(ADD_4_0_5, C_RTYPE, 32'd0, 32'h55, 32'h114);
    mem_regWrite = 1'b1; mem_rd = 5'd0; mem_result = 32'hFFFFFFFF;
    wb_regWrite  = 1'b1; wb_rd  = 5'd0; wb_data    = 32'hCCCCCCCC;
    expect_val("zero_opA", S_OPA, 32'd0);
    expect_val("zero_opB", S_OPB, 32'h55);
    tick();
    bypass_off();

    // lw into $0 never causes a stall
    drive(LW_0_8, C_LW, 32'h0, 32'h0, 32'h118);
    tick();
    drive(ADD_4_0_5, C_RTYPE, 32'd0, 32'h55, 32'h11C);
    check("lw_r0_stall", {31'd0, stall}, 32'd0);
    expect_val("lw_r0_valid", S_VALID, 32'd1);
    tick();

    // Flush together with hazard: bubble, no stall, counter unchanged
    drive(LW_9_8, C_LW, 32'h1000, 32'h33, 32'h120);
    tick();
    drive(ADD_8_9_10, C_RTYPE, 32'd1, 32'd2, 32'h124);
    flush = 1'b1; #1;
    check("flush_haz_stall", {31'd0, stall}, 32'd0);
    expect_bubble("flush_haz");
    expect_val("flush_haz_cnt", S_CNT, 32'd1);
    tick();
    flush = 1'b0;

    // Four more load-use stalls (alternating rs/rt dependence) saturate the counter
    for (int i = 0; i < 4; i++) begin
      drive(LW_9_8, C_LW, 32'h1000, 32'h33, 32'h200);
      expect_val("sat_lw_valid", S_VALID, 32'd1);
      tick();
      drive((i % 2 == 0) ? ADD_8_9_10 : SUB_8_10_9, C_RTYPE, 32'd1, 32'd2, 32'h204);
      check("sat_stall", {31'd0, stall}, 32'd1);
      exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
      expect_val("sat_cnt", S_CNT, exp_cnt);
      expect_val("sat_bubble_valid", S_VALID, 32'd0);
      tick();
    end

    // Reset in the middle of a stall
    drive(LW_9_8, C_LW, 32'h1000, 32'h33, 32'h300);
    tick();
    drive(SUB_8_10_9, C_RTYPE, 32'd1, 32'd2, 32'h304);
    check("pre_rst_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    expect_bubble("mid_rst");
    expect_val("mid_rst_cnt", S_CNT, 32'd0);
    expect_val("mid_rst_stall", S_STALL, 32'd0);
    tick();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on simulated time so the bench always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
